// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared op codes, FSM states and helpers for the multiply/divide unit
package md_pkg;

  localparam int MD_W  = 32;
  localparam int CNT_W = 4;

  typedef enum logic [3:0] {
    MD_NONE = 4'd0,
    MULT    = 4'd1,
    MULTU   = 4'd2,
    DIV     = 4'd3,
    DIVU    = 4'd4,
    MTHI    = 4'd5,
    MTLO    = 4'd6,
    MFHI    = 4'd7,
    MFLO    = 4'd8
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  function automatic logic is_md_start(input logic [3:0] op);
    return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// rtl/md_arith.sv - combinational multiply/divide datapath producing the pending HI/LO pair
module md_arith
  import md_pkg::*;
(
  input  logic [MD_W-1:0] a,
  input  logic [MD_W-1:0] b,
  input  logic [3:0]      op,
  input  logic [MD_W-1:0] cur_hi,
  input  logic [MD_W-1:0] cur_lo,
  output logic [MD_W-1:0] res_hi,
  output logic [MD_W-1:0] res_lo
);

  logic [2*MD_W-1:0] w_prod_s;
  logic [2*MD_W-1:0] w_prod_u;
  logic              w_b_zero;
  logic [MD_W-1:0]   w_a_mag;
  logic [MD_W-1:0]   w_b_mag;
  logic [MD_W-1:0]   w_q_mag;
  logic [MD_W-1:0]   w_r_mag;
  logic [MD_W-1:0]   w_q_s;
  logic [MD_W-1:0]   w_r_s;
  logic [MD_W-1:0]   w_b_safe;
  logic [MD_W-1:0]   w_q_u;
  logic [MD_W-1:0]   w_r_u;

  assign w_prod_s = $signed({{MD_W{a[MD_W-1]}}, a}) * $signed({{MD_W{b[MD_W-1]}}, b});
  assign w_prod_u = {{MD_W{1'b0}}, a} * {{MD_W{1'b0}}, b};

  // Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000 without overflow.
  assign w_b_zero = (b == '0);
  assign w_a_mag  = a[MD_W-1] ? (~a + 1'b1) : a;
  assign w_b_mag  = w_b_zero ? {{(MD_W-1){1'b0}}, 1'b1} : (b[MD_W-1] ? (~b + 1'b1) : b);
  assign w_q_mag  = w_a_mag / w_b_mag;
  assign w_r_mag  = w_a_mag % w_b_mag;
  assign w_q_s    = (a[MD_W-1] ^ b[MD_W-1]) ? (~w_q_mag + 1'b1) : w_q_mag;
  assign w_r_s    = a[MD_W-1] ? (~w_r_mag + 1'b1) : w_r_mag;

  assign w_b_safe = w_b_zero ? {{(MD_W-1){1'b0}}, 1'b1} : b;
  assign w_q_u    = a / w_b_safe;
  assign w_r_u    = a % w_b_safe;

  always_comb begin
    res_hi = cur_hi;
    res_lo = cur_lo;
    case (op)
      MULT:  {res_hi, res_lo} = w_prod_s;
      MULTU: {res_hi, res_lo} = w_prod_u;
      DIV:   if (!w_b_zero) begin
               res_hi = w_r_s;
               res_lo = w_q_s;
             end
      DIVU:  if (!w_b_zero) begin
               res_hi = w_r_u;
               res_lo = w_q_u;
             end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - E-stage multiply/divide unit with HI/LO registers and D-stage stall request
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      md_op,
  input  logic [MD_W-1:0] a,
  input  logic [MD_W-1:0] b,
  input  logic            d_uses_md,
  output logic            start,
  output logic            busy,
  output logic            md_stall,
  output logic [MD_W-1:0] hi,
  output logic [MD_W-1:0] lo,
  output logic [MD_W-1:0] md_out
);

  md_state_e        r_state;
  md_state_e        w_state_nx;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nx;
  logic [MD_W-1:0]  r_hi;
  logic [MD_W-1:0]  r_lo;
  logic [MD_W-1:0]  r_pend_hi;
  logic [MD_W-1:0]  r_pend_lo;
  logic [MD_W-1:0]  w_hi_nx;
  logic [MD_W-1:0]  w_lo_nx;
  logic [MD_W-1:0]  w_pend_hi_nx;
  logic [MD_W-1:0]  w_pend_lo_nx;
  logic [MD_W-1:0]  w_arith_hi;
  logic [MD_W-1:0]  w_arith_lo;
  logic             w_busy;
  logic             w_start;

  md_arith u_arith (
    .a      (a),
    .b      (b),
    .op     (md_op),
    .cur_hi (r_hi),
    .cur_lo (r_lo),
    .res_hi (w_arith_hi),
    .res_lo (w_arith_lo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_count   <= w_count_nx;
      r_hi      <= w_hi_nx;
      r_lo      <= w_lo_nx;
      r_pend_hi <= w_pend_hi_nx;
      r_pend_lo <= w_pend_lo_nx;
    end
  end

  // The result is captured at start so forwarded operands may change while the unit runs.
  always_comb begin
    w_state_nx   = r_state;
    w_count_nx   = r_count;
    w_hi_nx      = r_hi;
    w_lo_nx      = r_lo;
    w_pend_hi_nx = r_pend_hi;
    w_pend_lo_nx = r_pend_lo;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_pend_hi_nx = w_arith_hi;
          w_pend_lo_nx = w_arith_lo;
          w_count_nx   = ((md_op == MULT) || (md_op == MULTU)) ?
                         CNT_W'(MULT_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
          w_state_nx   = ST_RUN;
        end else if (md_op == MTHI) begin
          w_hi_nx = a;
        end else if (md_op == MTLO) begin
          w_lo_nx = a;
        end
      end
      ST_RUN: begin
        if (r_count == '0) begin
          w_hi_nx    = r_pend_hi;
          w_lo_nx    = r_pend_lo;
          w_state_nx = ST_IDLE;
        end else begin
          w_count_nx = r_count - 1'b1;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy   = (r_state == ST_RUN);
    w_start  = is_md_start(md_op) && !w_busy;
    md_stall = (w_start || w_busy) && d_uses_md;
    md_out   = '0;
    if (md_op == MFHI) begin
      md_out = r_hi;
    end else if (md_op == MFLO) begin
      md_out = r_lo;
    end
  end

  assign start = w_start;
  assign busy  = w_busy;
  assign hi    = r_hi;
  assign lo    = r_lo;

  always @(posedge clk) begin
    if (!reset && w_busy) begin
      assert (md_op == MD_NONE)
        else $warning("md_unit: md_op %0d presented while busy is ignored", md_op);
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - randomized self-checking bench for md_unit against an arithmetic reference model
module tb_md_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_uses_md;
  logic        start;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_out;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .md_op     (md_op),
    .a         (a),
    .b         (b),
    .d_uses_md (d_uses_md),
    .start     (start),
    .busy      (busy),
    .md_stall  (md_stall),
    .hi        (hi),
    .lo        (lo),
    .md_out    (md_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Reference computed with 64-bit host arithmetic; division of longint truncates toward zero.
  function automatic logic [63:0] md_expect(input logic [3:0] op, input logic [31:0] x,
                                            input logic [31:0] y, input logic [31:0] ch,
                                            input logic [31:0] cl);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p  = {ch, cl};
    case (op)
      MULT:  p = 64'(sx * sy);
      MULTU: p = {32'd0, x} * {32'd0, y};
      DIV:   if (y != 0) begin
               q = sx / sy;
               r = sx % sy;
               p = {r[31:0], q[31:0]};
             end
      DIVU:  if (y != 0) p = {x % y, x / y};
      default: ;
    endcase
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_md(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic du, input bit intrude);
    logic [63:0] e;
    int n;
    e = md_expect(op, x, y, model_hi, model_lo);
    n = ((op == MULT) || (op == MULTU)) ? 5 : 10;
    md_op = op; a = x; b = y; d_uses_md = du;
    #2;
    chk("start_c0", 32'(start), 32'd1);
    chk("stall_c0", 32'(md_stall), 32'(du));
    step();
    md_op = MD_NONE; a = $urandom; b = $urandom;
    for (int c = 1; c <= n; c++) begin
      if (intrude && c == 2) begin
        md_op = MULT;
        #1;
        chk("start_while_busy", 32'(start), 32'd0);
      end
      #1;
      chk("busy_run", 32'(busy), 32'd1);
      chk("stall_run", 32'(md_stall), 32'(du));
      chk("hi_hold", hi, model_hi);
      step();
      md_op = MD_NONE;
    end
    #1;
    chk("busy_done", 32'(busy), 32'd0);
    chk("stall_done", 32'(md_stall), 32'd0);
    chk("hi_result", hi, e[63:32]);
    chk("lo_result", lo, e[31:0]);
    model_hi = e[63:32];
    model_lo = e[31:0];
    md_op = MFHI;
    #1;
    chk("mfhi_new", md_out, model_hi);
    md_op = MFLO;
    #1;
    chk("mflo_new", md_out, model_lo);
    md_op = MD_NONE;
    d_uses_md = 1'b0;
    step();
  endtask

  task automatic move_to(input logic [3:0] op, input logic [31:0] x);
    md_op = op; a = x;
    #2;
    chk("mt_start", 32'(start), 32'd0);
    step();
    md_op = MD_NONE;
    if (op == MTHI) model_hi = x;
    else model_lo = x;
    #1;
    chk("mt_busy", 32'(busy), 32'd0);
    chk("mt_hi", hi, model_hi);
    chk("mt_lo", lo, model_lo);
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    reset = 1'b1; md_op = MFHI; a = '0; b = '0; d_uses_md = 1'b1;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_md_out", md_out, 32'd0);
    md_op = MD_NONE;
    #1;
    chk("rst_stall", 32'(md_stall), 32'd0);
    step();
    step();
    reset = 1'b0;
    d_uses_md = 1'b0;
    step();

    run_md(MULT,  32'hFFFFFFFF, 32'd2, 1'b0, 1'b0);
    run_md(MULTU, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0);
    run_md(DIV,   32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
    run_md(DIVU,  32'd7,        32'd2, 1'b0, 1'b0);

    move_to(MTHI, 32'h12345678);
    md_op = MFLO;
    #1;
    chk("mflo_after_mthi", md_out, model_lo);
    md_op = MFHI;
    #1;
    chk("mfhi_after_mthi", md_out, 32'h12345678);
    md_op = MD_NONE;
    step();
    run_md(DIV,  32'd100, 32'd0, 1'b0, 1'b0);
    run_md(DIVU, 32'd55,  32'd0, 1'b1, 1'b0);

    run_md(MULT, 32'd6, 32'hFFFFFFFD, 1'b1, 1'b0);
    run_md(MULT, 32'd9, 32'd9,        1'b0, 1'b0);
    run_md(DIV,  32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    run_md(DIV,  32'd7, 32'hFFFFFFFE, 1'b0, 1'b0);

    md_op = DIV; a = 32'd1000; b = 32'd7;
    step();
    md_op = MD_NONE;
    step();
    step();
    reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    model_hi = '0;
    model_lo = '0;
    step();
    reset = 1'b0;
    step();
    run_md(MULT, 32'd3, 32'd4, 1'b0, 1'b0);

    run_md(MULTU, 32'hDEADBEEF, 32'h01234567, 1'b1, 1'b1);

    for (int i = 0; i < 24; i++) begin
      rop = 4'($urandom_range(1, 6));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if (i % 5 == 0) rb = rb >> $urandom_range(0, 31);
      if ((rop == MTHI) || (rop == MTLO)) begin
        move_to(rop, ra);
      end else begin
        run_md(rop, ra, rb, 1'($urandom_range(0, 1)), 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
